// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: per-frame snapshot, leading-zero
// blanking, one-cycle dead time and PWM dimming, all from one clock.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 25000000,
    parameter int SCAN_HZ  = 1000,
    parameter int DIM_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [DIM_BITS-1:0]   bright,
    output logic [DIGITS-1:0]     com,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int SLOT  = CLK_HZ / SCAN_HZ;
    localparam int PHASE = SLOT >> DIM_BITS;
    localparam int CW    = $clog2(SLOT);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]       CYC_LAST   = CW'(SLOT - 1);
    localparam logic [IW-1:0]       IDX_TOP    = IW'(DIGITS - 1);
    localparam logic [DIM_BITS-1:0] BRIGHT_MAX = '1;

    typedef enum logic [1:0] {
        DEAD,
        ON,
        OFF
    } slot_st_t;

    logic [CW-1:0]       cyc_q, cyc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                sh_blz_q, sh_blz_d;
    logic [DIGITS-1:0]   com_q, com_d;
    logic [7:0]          seg_q, seg_d;
    logic                fs_q, fs_d;

    logic                capture;
    slot_st_t            slot_st;
    logic [3:0]          dig_sel;
    logic [7:0]          font_v;
    logic [DIGITS-1:0]   blank_vec;
    logic                zero_run;

    function automatic logic [7:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 8'h03;
            4'h1: font = 8'h9F;
            4'h2: font = 8'h25;
            4'h3: font = 8'h0D;
            4'h4: font = 8'h99;
            4'h5: font = 8'h49;
            4'h6: font = 8'h41;
            4'h7: font = 8'h1F;
            4'h8: font = 8'h01;
            4'h9: font = 8'h09;
            4'hA: font = 8'h11;
            4'hB: font = 8'hC1;
            4'hC: font = 8'h63;
            4'hD: font = 8'h85;
            4'hE: font = 8'h61;
            default: font = 8'h71;
        endcase
    endfunction

    always_comb begin
        capture  = (cyc_q == '0) && (idx_q == IDX_TOP);
        sh_dig_d = capture ? digits   : sh_dig_q;
        sh_dp_d  = capture ? dp       : sh_dp_q;
        sh_blz_d = capture ? blank_lz : sh_blz_q;

        cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
        idx_d = idx_q;
        if (cyc_q == CYC_LAST) begin
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
        end

        // p <= bright is the same as cyc < (bright+1)*PHASE unless bright saturates
        if (cyc_q == '0) begin
            slot_st = DEAD;
        end else if (bright == BRIGHT_MAX ||
                     int'(cyc_q) < (int'(bright) + 1) * PHASE) begin
            slot_st = ON;
        end else begin
            slot_st = OFF;
        end

        com_d = '0;
        if (slot_st == ON) begin
            com_d[idx_q] = 1'b1;
        end

        // Decode from the post-capture view so the first slot shows fresh data
        blank_vec = '0;
        zero_run  = sh_blz_d;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (sh_dig_d[4*k +: 4] == 4'h0);
            blank_vec[k] = zero_run;
        end

        dig_sel = sh_dig_d[4*idx_q +: 4];
        font_v  = font(dig_sel);
        seg_d   = {blank_vec[idx_q] ? 7'h7F : font_v[7:1], ~sh_dp_d[idx_q]};
        fs_d    = capture;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q    <= '0;
            idx_q    <= IDX_TOP;
            sh_dig_q <= '0;
            sh_dp_q  <= '0;
            sh_blz_q <= 1'b0;
            com_q    <= '0;
            seg_q    <= 8'hFF;
            fs_q     <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            idx_q    <= idx_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            sh_blz_q <= sh_blz_d;
            com_q    <= com_d;
            seg_q    <= seg_d;
            fs_q     <= fs_d;
        end
    end

    assign com         = com_q;
    assign seg         = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: table vectors, corner sequences and
// random stimulus against a cycle-count based reference model.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic [3:0]  com;
    logic [7:0]  seg;
    logic        frame_start;

    seg_scan_driver #(
        .DIGITS  (4),
        .CLK_HZ  (64),
        .SCAN_HZ (4),
        .DIM_BITS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .com        (com),
        .seg        (seg),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] FONT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    // Reference model state: cycles since reset release and frame snapshot
    int          c = 0;
    logic [15:0] m_dig = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic        m_blz = 1'b0;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp,
                     $time);
        end
    endtask

    task automatic tick();
        int cy, ix, p, dv;
        logic [7:0] es, fv;
        logic [3:0] ec;
        logic       ef, bl;
        @(posedge clk);
        cy = c % 16;
        ix = 3 - (c / 16) % 4;
        ef = (c % 64 == 0);
        if (ef) begin
            m_dig = digits;
            m_dp  = dp;
            m_blz = blank_lz;
        end
        p = cy / 4;
        if (p > 3) p = 3;
        ec = (cy != 0 && p <= int'(bright)) ? 4'(1 << ix) : 4'b0;
        dv = int'((m_dig >> (4 * ix)) & 16'hF);
        bl = (ix >= 1) && m_blz && ((m_dig >> (4 * ix)) == 16'h0);
        fv = FONT[dv];
        es = {bl ? 7'h7F : fv[7:1], ~m_dp[ix]};
        c++;
        #1;
        chk("com", 8'(com), 8'(ec));
        chk("seg", seg, es);
        chk("frame_start", 8'(frame_start), 8'(ef));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_com", 8'(com), 8'h00);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_fs", 8'(frame_start), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        c = 0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dpv;
        logic        blz;
        logic [1:0]  br;
        logic [7:0]  s3, s2, s1, s0;
        int          lit;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    logic [7:0] gs  [4];
    logic [7:0] gs1 [4];
    int         lit [4];
    int         fs_cnt;
    int         ix;

    initial begin
        tbl[0] = '{16'h1234, 4'h0, 1'b0, 2'd3, 8'h9F, 8'h25, 8'h0D, 8'h99, 15};
        tbl[1] = '{16'h0005, 4'h0, 1'b1, 2'd3, 8'hFF, 8'hFF, 8'hFF, 8'h49, 15};
        tbl[2] = '{16'h0000, 4'h0, 1'b1, 2'd3, 8'hFF, 8'hFF, 8'hFF, 8'h03, 15};
        tbl[3] = '{16'h0000, 4'h4, 1'b1, 2'd3, 8'hFF, 8'hFE, 8'hFF, 8'h03, 15};
        tbl[4] = '{16'h1234, 4'h0, 1'b0, 2'd0, 8'h9F, 8'h25, 8'h0D, 8'h99, 3};
        tbl[5] = '{16'h1234, 4'h0, 1'b0, 2'd1, 8'h9F, 8'h25, 8'h0D, 8'h99, 7};
        tbl[6] = '{16'h1234, 4'h0, 1'b0, 2'd2, 8'h9F, 8'h25, 8'h0D, 8'h99, 11};
        tbl[7] = '{16'hABCD, 4'hF, 1'b0, 2'd3, 8'h10, 8'hC0, 8'h62, 8'h84, 15};
        tbl[8] = '{16'h0005, 4'h0, 1'b0, 2'd3, 8'h03, 8'h03, 8'h03, 8'h49, 15};

        for (int i = 0; i < NV; i++) begin
            digits   = tbl[i].d;
            dp       = tbl[i].dpv;
            blank_lz = tbl[i].blz;
            bright   = tbl[i].br;
            do_reset();
            for (int k = 0; k < 4; k++) begin
                lit[k] = 0;
                gs[k]  = 8'h00;
            end
            for (int e = 0; e < 64; e++) begin
                tick();
                ix = 3 - e / 16;
                if (com == (4'b1 << ix)) lit[ix]++;
                if (e % 16 == 8) gs[ix] = seg;
            end
            chk("tbl_seg3", gs[3], tbl[i].s3);
            chk("tbl_seg2", gs[2], tbl[i].s2);
            chk("tbl_seg1", gs[1], tbl[i].s1);
            chk("tbl_seg0", gs[0], tbl[i].s0);
            for (int k = 0; k < 4; k++) begin
                chk("tbl_lit", 8'(lit[k]), 8'(tbl[i].lit));
            end
        end

        // Mid-frame input change stays hidden until the next snapshot
        digits = 16'h1234; dp = 4'h0; blank_lz = 1'b0; bright = 2'd3;
        do_reset();
        fs_cnt = 0;
        for (int e = 0; e < 128; e++) begin
            tick();
            if (frame_start) fs_cnt++;
            ix = 3 - (e % 64) / 16;
            if (e % 16 == 8) begin
                if (e < 64) gs[ix] = seg;
                else gs1[ix] = seg;
            end
            if (e == 19) digits = 16'hABCD;
        end
        chk("coh_f0_s2", gs[2], 8'h25);
        chk("coh_f0_s1", gs[1], 8'h0D);
        chk("coh_f0_s0", gs[0], 8'h99);
        chk("coh_f1_s3", gs1[3], 8'h11);
        chk("coh_f1_s2", gs1[2], 8'hC1);
        chk("coh_f1_s1", gs1[1], 8'h63);
        chk("coh_f1_s0", gs1[0], 8'h85);
        chk("coh_fs_cnt", 8'(fs_cnt), 8'd2);

        // Asynchronous reset in the middle of slot 1
        digits = 16'h1234;
        do_reset();
        for (int e = 0; e < 40; e++) tick();
        chk("mid_com_before", 8'(com), 8'h02);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_async_com", 8'(com), 8'h00);
        chk("mid_async_seg", seg, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        c = 0;
        tick();
        chk("mid_restart_fs", 8'(frame_start), 8'h01);
        tick();
        chk("mid_restart_com", 8'(com), 8'h08);
        chk("mid_restart_seg", seg, 8'h9F);

        // Random stimulus against the model
        do_reset();
        for (int e = 0; e < 1500; e++) begin
            tick();
            bright = 2'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 1) == 1)
                    digits = digits >> (4 * $urandom_range(1, 4));
                dp       = 4'($urandom);
                blank_lz = 1'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
